alu_acc_flag_ctrl: RTL and testbench

//  Accumulator/flag control stage wrapped around the 8-bit ALU (alu_8bit). Accepts ALU commands

---
 rtl/alu_ctrl_pkg.sv | 28 ++
 rtl/alu_flag_gen.sv | 25 ++
 rtl/alu_acc_flag_ctrl.sv | 113 +++++++++++
 tb/tb_alu_acc_flag_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the accumulator/flag control stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Flag register layout {S,Z,AC,P,CY}
    localparam int FLAG_W = 5;
    localparam int FLG_S  = 4;
    localparam int FLG_Z  = 3;
    localparam int FLG_AC = 2;
    localparam int FLG_P  = 1;
    localparam int FLG_CY = 0;

    // Command kinds
    localparam logic CMD_ALU  = 1'b0;
    localparam logic CMD_LOAD = 1'b1;

    // Settle counter width, enough for EXEC_CYCLES up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/alu_flag_gen.sv
// 8085-style flag derivation from an ALU result and carry.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module alu_flag_gen
    import alu_ctrl_pkg::*;
(
    input  logic [7:0]        r,
    input  logic              carry,
    input  logic              a4,
    input  logic              b4,
    output logic [FLAG_W-1:0] flags
);

    // Auxiliary carry is recovered from bit 4 of both operands and the
    // result, so it is meaningful for add/sub and harmless for logic ops.
    always_comb begin
        flags         = '0;
        flags[FLG_S]  = r[7];
        flags[FLG_Z]  = (r == 8'h00);
        flags[FLG_AC] = a4 ^ b4 ^ r[4];
        flags[FLG_P]  = ~^r;
        flags[FLG_CY] = carry;
    end

endmodule

// File: rtl/alu_acc_flag_ctrl.sv
// Accumulator/flag writeback stage around an external 8-bit combinational ALU.
// Latency: ALU command -> rsp_valid EXEC_CYCLES+1 cycles after accept; LOAD -> 1 cycle.
// Backpressure: one command in flight; cmd_ready low until the response is consumed.
module alu_acc_flag_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int         EXEC_CYCLES = 1,
    parameter logic [7:0] ACC_RESET   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_kind,
    input  logic [3:0]        cmd_op,
    input  logic [7:0]        cmd_data,
    input  logic              cmd_acc_we,
    input  logic              cmd_flag_we,
    output logic [7:0]        alu_operand_a,
    output logic [7:0]        alu_operand_b,
    output logic [3:0]        alu_operation,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        acc_q,
    output logic [FLAG_W-1:0] flags_q
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               acc_we_q;
    logic               flag_we_q;
    logic [FLAG_W-1:0]  flag_next;

    // Operand A is the accumulator itself; it cannot move during EXEC
    // because the accumulator is only written at the end of EXEC.
    assign alu_operand_a = acc_q;
    assign cmd_ready     = (state_q == IDLE);

    alu_flag_gen u_flag_gen (
        .r     (alu_result),
        .carry (alu_carry_out),
        .a4    (acc_q[4]),
        .b4    (alu_operand_b[4]),
        .flags (flag_next)
    );

    // Control FSM with accumulator, flag and ALU-input registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_we_q      <= 1'b0;
            flag_we_q     <= 1'b0;
            alu_operand_b <= 8'h00;
            alu_operation <= 4'h0;
            rsp_valid     <= 1'b0;
            acc_q         <= ACC_RESET;
            flags_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_kind == CMD_LOAD) begin
                            // LOAD bypasses the ALU and never touches flags
                            // or the ALU input registers.
                            if (cmd_acc_we) begin
                                acc_q <= cmd_data;
                            end
                            rsp_valid <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            alu_operand_b <= cmd_data;
                            alu_operation <= cmd_op;
                            acc_we_q      <= cmd_acc_we;
                            flag_we_q     <= cmd_flag_we;
                            cnt_q         <= CNT_INIT;
                            state_q       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        if (acc_we_q) begin
                            acc_q <= alu_result;
                        end
                        if (flag_we_q) begin
                            flags_q <= flag_next;
                        end
                        rsp_valid <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_flag_ctrl.sv
// Self-checking bench for alu_acc_flag_ctrl with a behavioural ALU model.
// Latency: n/a.
// Backpressure: exercised via held rsp_ready and held cmd_valid.
module tb_alu_acc_flag_ctrl;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;

    // Default-parameter instance
    logic       cmd_valid, cmd_ready, cmd_kind, cmd_acc_we, cmd_flag_we;
    logic [3:0] cmd_op, alu_operation;
    logic [7:0] cmd_data, alu_operand_a, alu_operand_b, alu_result, acc_q;
    logic       alu_carry_out, rsp_valid, rsp_ready;
    logic [4:0] flags_q;

    // Slow instance: EXEC_CYCLES=3, non-zero reset value
    logic       b_cmd_valid, b_cmd_ready, b_cmd_kind, b_cmd_acc_we, b_cmd_flag_we;
    logic [3:0] b_cmd_op, b_alu_operation;
    logic [7:0] b_cmd_data, b_alu_operand_a, b_alu_operand_b, b_alu_result, b_acc_q;
    logic       b_alu_carry_out, b_rsp_valid, b_rsp_ready;
    logic [4:0] b_flags_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ALU model: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, else pass A
    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [8:0] s;
        case (op)
            4'd0:    s = {1'b0, a} + {1'b0, b};
            4'd1:    s = {(a < b), 8'(a - b)};
            4'd2:    s = {1'b0, a & b};
            4'd3:    s = {1'b0, a | b};
            4'd4:    s = {1'b0, a ^ b};
            default: s = {1'b0, a};
        endcase
        return s;
    endfunction

    assign {alu_carry_out, alu_result}     = alu_model(alu_operation, alu_operand_a, alu_operand_b);
    assign {b_alu_carry_out, b_alu_result} = alu_model(b_alu_operation, b_alu_operand_a, b_alu_operand_b);

    alu_acc_flag_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_acc_we(cmd_acc_we), .cmd_flag_we(cmd_flag_we),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .acc_q(acc_q), .flags_q(flags_q)
    );

    alu_acc_flag_ctrl #(.EXEC_CYCLES(3), .ACC_RESET(8'hA5)) u_dut_slow (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_kind(b_cmd_kind),
        .cmd_op(b_cmd_op), .cmd_data(b_cmd_data), .cmd_acc_we(b_cmd_acc_we), .cmd_flag_we(b_cmd_flag_we),
        .alu_operand_a(b_alu_operand_a), .alu_operand_b(b_alu_operand_b), .alu_operation(b_alu_operation),
        .alu_result(b_alu_result), .alu_carry_out(b_alu_carry_out),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .acc_q(b_acc_q), .flags_q(b_flags_q)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       kind;
        logic [3:0] op;
        logic [7:0] data;
        logic       acc_we;
        logic       flag_we;
        int         hold;      // cycles rsp_ready stays low once rsp_valid is seen
        logic [7:0] exp_acc;
        logic [4:0] exp_flags; // {S,Z,AC,P,CY}
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] last_b;
    logic [3:0] last_op;

    // Issue one command on the default instance and check its response
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int exp_lat;
        @(negedge clk);
        cmd_kind = v.kind; cmd_op = v.op; cmd_data = v.data;
        cmd_acc_we = v.acc_we; cmd_flag_we = v.flag_we;
        cmd_valid = 1'b1; rsp_ready = 1'b0;
        chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        exp_lat = (v.kind == CMD_LOAD) ? 1 : 2;
        chk($sformatf("v%0d_latency", idx), n, exp_lat);
        chk($sformatf("v%0d_acc", idx), acc_q, v.exp_acc);
        chk($sformatf("v%0d_flags", idx), flags_q, v.exp_flags);
        if (v.kind == CMD_ALU) begin
            last_b  = v.data;
            last_op = v.op;
        end
        chk($sformatf("v%0d_alu_b", idx), alu_operand_b, last_b);
        chk($sformatf("v%0d_alu_op", idx), alu_operation, last_op);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_hold%0d_vld", idx, i), rsp_valid, 1'b1);
            chk($sformatf("v%0d_hold%0d_acc", idx, i), acc_q, v.exp_acc);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_rsp_drop", idx), rsp_valid, 1'b0);
        chk($sformatf("v%0d_idle_rdy", idx), cmd_ready, 1'b1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        // kind      op     data   awe   fwe   hold  acc    flags
        vecs[0] = '{CMD_LOAD, 4'd0, 8'h33, 1'b1, 1'b0, 0, 8'h33, 5'b00000};
        vecs[1] = '{CMD_ALU,  4'd0, 8'hCC, 1'b1, 1'b1, 0, 8'hFF, 5'b10010};
        vecs[2] = '{CMD_ALU,  4'd0, 8'h01, 1'b1, 1'b1, 1, 8'h00, 5'b01111};
        vecs[3] = '{CMD_LOAD, 4'd7, 8'h5A, 1'b1, 1'b1, 0, 8'h5A, 5'b01111};
        vecs[4] = '{CMD_LOAD, 4'd0, 8'h10, 1'b1, 1'b0, 0, 8'h10, 5'b01111};
        vecs[5] = '{CMD_ALU,  4'd1, 8'h10, 1'b0, 1'b1, 0, 8'h10, 5'b01010};
        vecs[6] = '{CMD_ALU,  4'd2, 8'h0F, 1'b1, 1'b0, 0, 8'h00, 5'b01010};
        vecs[7] = '{CMD_LOAD, 4'd0, 8'h77, 1'b0, 1'b0, 0, 8'h00, 5'b01010};
        vecs[8] = '{CMD_ALU,  4'd4, 8'h81, 1'b1, 1'b1, 3, 8'h81, 5'b10010};
        vecs[9] = '{CMD_ALU,  4'd0, 8'h80, 1'b1, 1'b1, 0, 8'h01, 5'b00001};

        last_b = 8'h00; last_op = 4'h0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_kind = 1'b0; cmd_op = 4'h0; cmd_data = 8'h00;
        cmd_acc_we = 1'b0; cmd_flag_we = 1'b0; rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_kind = 1'b0; b_cmd_op = 4'h0; b_cmd_data = 8'h00;
        b_cmd_acc_we = 1'b0; b_cmd_flag_we = 1'b0; b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_acc", acc_q, 8'h00);
        chk("rst_flags", flags_q, 5'b00000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_alu_b", alu_operand_b, 8'h00);
        chk("rst_slow_acc", b_acc_q, 8'hA5);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: response held 5 cycles while the next command waits
        @(negedge clk);
        cmd_kind = CMD_ALU; cmd_op = 4'd0; cmd_data = 8'h02;   // 01 + 02 = 03
        cmd_acc_we = 1'b1; cmd_flag_we = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_kind = CMD_LOAD; cmd_data = 8'hC3; cmd_acc_we = 1'b1; cmd_flag_we = 1'b0;
        chk("bp_exec_rdy", cmd_ready, 1'b0);
        @(negedge clk);
        chk("bp_rsp_vld", rsp_valid, 1'b1);
        chk("bp_acc", acc_q, 8'h03);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_vld", i), rsp_valid, 1'b1);
            chk($sformatf("bp_hold%0d_acc", i), acc_q, 8'h03);
            chk($sformatf("bp_hold%0d_rdy", i), cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_rdy", cmd_ready, 1'b1);
        chk("bp_idle_vld", rsp_valid, 1'b0);
        chk("bp_not_taken", acc_q, 8'h03);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_load_vld", rsp_valid, 1'b1);
        chk("bp_load_acc", acc_q, 8'hC3);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Slow instance: EXEC_CYCLES=3, rsp_ready already high -> one-cycle response
        b_cmd_kind = CMD_ALU; b_cmd_op = 4'd0; b_cmd_data = 8'h01;
        b_cmd_acc_we = 1'b1; b_cmd_flag_we = 1'b1; b_cmd_valid = 1'b1; b_rsp_ready = 1'b1;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        n = 1;
        while (!b_rsp_valid && n < 30) begin
            chk($sformatf("slow_exec%0d_rdy", n), b_cmd_ready, 1'b0);
            chk($sformatf("slow_exec%0d_acc", n), b_acc_q, 8'hA5);
            @(negedge clk);
            n++;
        end
        chk("slow_latency", n, 4);
        chk("slow_acc", b_acc_q, 8'hA6);
        chk("slow_flags", b_flags_q, 5'b10010);
        @(negedge clk);
        chk("slow_one_cycle_vld", b_rsp_valid, 1'b0);
        chk("slow_back_idle", b_cmd_ready, 1'b1);
        b_rsp_ready = 1'b0;

        // Reset during EXEC: command dropped, everything back to reset values
        @(negedge clk);
        cmd_kind = CMD_ALU; cmd_op = 4'd0; cmd_data = 8'h11;
        cmd_acc_we = 1'b1; cmd_flag_we = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_exec_rdy", cmd_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_acc", acc_q, 8'h00);
        chk("arst_flags", flags_q, 5'b00000);
        chk("arst_alu_b", alu_operand_b, 8'h00);
        chk("arst_vld", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_rdy", i), cmd_ready, 1'b1);
            chk($sformatf("post_rst%0d_vld", i), rsp_valid, 1'b0);
            chk($sformatf("post_rst%0d_acc", i), acc_q, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
